// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run request in, counters, strobes and VGA sync/blank out.
// master = timing generator, slave = downstream pixel pipeline / observer.
interface vga_timing_gen_if #(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 10
);
  logic          enable;
  logic          running;
  logic          pix_en;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic          VGA_CLK;
  logic          VGA_HS;
  logic          VGA_VS;
  logic          VGA_BLANK_n;
  logic          VGA_SYNC_n;

  modport master (
    input  enable,
    output running, pix_en, hcount, vcount, active, line_start, frame_start,
           VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n
  );

  modport slave (
    output enable,
    input  running, pix_en, hcount, vcount, active, line_start, frame_start,
           VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, start strobes,
// run/stop control with frame-aligned stop, and delayed sync/blank with polarity.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned HS_POL     = 0,
  parameter int unsigned VS_POL     = 0,
  parameter int unsigned PIPE_DELAY = 0
) (
  input  logic             clk50,
  input  logic             reset_n,
  vga_timing_gen_if.master vga_io
);
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned DW       = $clog2(CLK_DIV);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic [HW-1:0] hcnt_q;
  logic [VW-1:0] vcnt_q;

  logic running, pix_en, h_last, v_last, frame_end;
  logic hs_raw, vs_raw, blank_raw;
  logic hs_del, vs_del, blank_del;

  assign running   = (state_q != StIdle);
  assign pix_en    = running && (32'(div_q) == CLK_DIV - 1);
  assign h_last    = (32'(hcnt_q) == H_TOTAL - 1);
  assign v_last    = (32'(vcnt_q) == V_TOTAL - 1);
  assign frame_end = pix_en && h_last && v_last;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (vga_io.enable) state_q <= StRun;
        StRun:  if (!vga_io.enable) state_q <= StStop;
        // Re-arming wins over the frame-end exit so a resume never drops a frame.
        StStop: begin
          if (vga_io.enable) state_q <= StRun;
          else if (frame_end) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (running) begin
        div_q <= pix_en ? '0 : div_q + DW'(1);
        if (pix_en) begin
          hcnt_q <= h_last ? '0 : hcnt_q + HW'(1);
          if (h_last) vcnt_q <= v_last ? '0 : vcnt_q + VW'(1);
        end
      end else begin
        div_q  <= '0;
        hcnt_q <= '0;
        vcnt_q <= '0;
      end
    end
  end

  // Raw sync/blank in asserted-high sense; polarity is applied only at the pins.
  assign blank_raw = running && (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
  assign hs_raw    = running && (32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END);
  assign vs_raw    = running && (32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END);

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign hs_del    = hs_raw;
      assign vs_del    = vs_raw;
      assign blank_del = blank_raw;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe_q, vs_pipe_q, bl_pipe_q;

      // Each stage holds one pixel period, so the lag is PIPE_DELAY*CLK_DIV clocks.
      always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe_q <= '0;
          vs_pipe_q <= '0;
          bl_pipe_q <= '0;
        end else if (!running) begin
          hs_pipe_q <= '0;
          vs_pipe_q <= '0;
          bl_pipe_q <= '0;
        end else if (pix_en) begin
          hs_pipe_q <= (hs_pipe_q << 1) | PIPE_DELAY'(hs_raw);
          vs_pipe_q <= (vs_pipe_q << 1) | PIPE_DELAY'(vs_raw);
          bl_pipe_q <= (bl_pipe_q << 1) | PIPE_DELAY'(blank_raw);
        end
      end

      assign hs_del    = hs_pipe_q[PIPE_DELAY-1];
      assign vs_del    = vs_pipe_q[PIPE_DELAY-1];
      assign blank_del = bl_pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  assign vga_io.running     = running;
  assign vga_io.pix_en      = pix_en;
  assign vga_io.hcount      = hcnt_q;
  assign vga_io.vcount      = vcnt_q;
  assign vga_io.active      = blank_raw;
  assign vga_io.line_start  = running && (div_q == '0) && (hcnt_q == '0);
  assign vga_io.frame_start = running && (div_q == '0) && (hcnt_q == '0) && (vcnt_q == '0);
  assign vga_io.VGA_CLK     = running && (32'(div_q) >= CLK_DIV / 2);
  assign vga_io.VGA_HS      = hs_del ^ (HS_POL == 0);
  assign vga_io.VGA_VS      = vs_del ^ (VS_POL == 0);
  assign vga_io.VGA_BLANK_n = blank_del;
  assign vga_io.VGA_SYNC_n  = 1'b1;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small/polarity-high, delayed, defaults),
// per-pixel expectations queued at enable and compared on each pix_en.
module tb_vga_timing_gen;
  logic clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
    bit act;
  } pix_t;

  vga_timing_gen_if #(.HW(4), .VW(3))   bus_a ();
  vga_timing_gen_if #(.HW(4), .VW(3))   bus_b ();
  vga_timing_gen_if #(.HW(10), .VW(10)) bus_c ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .CLK_DIV(4), .HS_POL(1), .VS_POL(1), .PIPE_DELAY(0)
  ) dut_a (.clk50(clk50), .reset_n(rst_a), .vga_io(bus_a));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .CLK_DIV(2), .HS_POL(0), .VS_POL(0), .PIPE_DELAY(2)
  ) dut_b (.clk50(clk50), .reset_n(rst_b), .vga_io(bus_b));

  vga_timing_gen dut_c (.clk50(clk50), .reset_n(rst_c), .vga_io(bus_c));

  // A: 14x7 pixels, 4 clocks/pixel, sync asserted high.
  function automatic pix_t model_a(int g);
    pix_t p;
    p.h   = g % 14;
    p.v   = (g / 14) % 7;
    p.hs  = (p.h >= 10 && p.h < 12);
    p.vs  = (p.v == 5);
    p.bl  = (p.h < 8 && p.v < 4);
    p.act = p.bl;
    return p;
  endfunction

  // B: 15x8 pixels, sync active-low, sync/blank two pixels behind the counters.
  function automatic pix_t model_b(int g);
    pix_t p;
    int   h2, v2;
    p.h   = g % 15;
    p.v   = (g / 15) % 8;
    p.act = (p.h < 8 && p.v < 4);
    if (g >= 2) begin
      h2   = (g - 2) % 15;
      v2   = ((g - 2) / 15) % 8;
      p.hs = !(h2 >= 10 && h2 < 13);
      p.vs = !(v2 == 5 || v2 == 6);
      p.bl = (h2 < 8 && v2 < 4);
    end else begin
      p.hs = 1'b1;
      p.vs = 1'b1;
      p.bl = 1'b0;
    end
    return p;
  endfunction

  // C: default 800x525 timing, only the first lines are exercised.
  function automatic pix_t model_c(int g);
    pix_t p;
    p.h   = g % 800;
    p.v   = g / 800;
    p.hs  = !(p.h >= 656 && p.h < 752);
    p.vs  = 1'b1;
    p.bl  = (p.h < 640);
    p.act = p.bl;
    return p;
  endfunction

  task automatic test_reset();
    logic [9:0] got;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) @(negedge clk50);
    got = {bus_a.running, bus_a.pix_en, bus_a.active, bus_a.line_start, bus_a.frame_start,
           bus_a.VGA_CLK, bus_a.VGA_HS, bus_a.VGA_VS, bus_a.VGA_BLANK_n, bus_a.VGA_SYNC_n};
    checks++;
    if (got !== 10'b0000000001 || bus_a.hcount !== 4'd0 || bus_a.vcount !== 3'd0) begin
      errors++;
      $display("FAIL reset_a: got outs=%b h=%0d v=%0d, want outs=0000000001 h=0 v=0",
               got, bus_a.hcount, bus_a.vcount);
    end
    got = {bus_b.running, bus_b.pix_en, bus_b.active, bus_b.line_start, bus_b.frame_start,
           bus_b.VGA_CLK, bus_b.VGA_HS, bus_b.VGA_VS, bus_b.VGA_BLANK_n, bus_b.VGA_SYNC_n};
    checks++;
    if (got !== 10'b0000001101 || bus_b.hcount !== 4'd0 || bus_b.vcount !== 3'd0) begin
      errors++;
      $display("FAIL reset_b: got outs=%b h=%0d v=%0d, want outs=0000001101 h=0 v=0",
               got, bus_b.hcount, bus_b.vcount);
    end
    got = {bus_c.running, bus_c.pix_en, bus_c.active, bus_c.line_start, bus_c.frame_start,
           bus_c.VGA_CLK, bus_c.VGA_HS, bus_c.VGA_VS, bus_c.VGA_BLANK_n, bus_c.VGA_SYNC_n};
    checks++;
    if (got !== 10'b0000001101 || bus_c.hcount !== 10'd0 || bus_c.vcount !== 10'd0) begin
      errors++;
      $display("FAIL reset_c: got outs=%b h=%0d v=%0d, want outs=0000001101 h=0 v=0",
               got, bus_c.hcount, bus_c.vcount);
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (5) @(negedge clk50);
    checks++;
    if (bus_a.running !== 1'b0 || bus_a.pix_en !== 1'b0 || bus_a.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got run=%b pix=%b fs=%b, want 0 0 0",
               bus_a.running, bus_a.pix_en, bus_a.frame_start);
    end
  endtask

  // Two frames on A with enable high, then a drop at (3,2) of the second frame.
  task automatic test_small_frame();
    pix_t q[$];
    pix_t e;
    for (int g = 0; g < 196; g++) q.push_back(model_a(g));
    bus_a.enable = 1'b1;
    for (int t = 0; t < 784; t++) begin
      @(negedge clk50);
      checks++;
      if (bus_a.running !== 1'b1 || bus_a.pix_en !== (t % 4 == 3) ||
          bus_a.VGA_CLK !== (t % 4 >= 2) || bus_a.frame_start !== (t % 392 == 0) ||
          bus_a.line_start !== (t % 56 == 0)) begin
        errors++;
        $display("FAIL a_strobe t=%0d: got run/pix/clk/fs/ls=%b%b%b%b%b, want 1%b%b%b%b", t,
                 bus_a.running, bus_a.pix_en, bus_a.VGA_CLK, bus_a.frame_start,
                 bus_a.line_start, t % 4 == 3, t % 4 >= 2, t % 392 == 0, t % 56 == 0);
      end
      if (bus_a.pix_en === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL a_pixel t=%0d: got pix_en, want no pixel left", t);
        end else begin
          e = q.pop_front();
          if (bus_a.hcount !== 4'(e.h) || bus_a.vcount !== 3'(e.v) || bus_a.VGA_HS !== e.hs ||
              bus_a.VGA_VS !== e.vs || bus_a.VGA_BLANK_n !== e.bl || bus_a.active !== e.act) begin
            errors++;
            $display("FAIL a_pixel t=%0d: got h=%0d v=%0d hs=%b vs=%b bl=%b act=%b, want %0d %0d %b %b %b %b",
                     t, bus_a.hcount, bus_a.vcount, bus_a.VGA_HS, bus_a.VGA_VS,
                     bus_a.VGA_BLANK_n, bus_a.active, e.h, e.v, e.hs, e.vs, e.bl, e.act);
          end
        end
      end
      if (t == 516) bus_a.enable = 1'b0;
    end
    @(negedge clk50);
    checks++;
    if (q.size() != 0 || bus_a.running !== 1'b0 || bus_a.hcount !== 4'd0 ||
        bus_a.vcount !== 3'd0 || bus_a.pix_en !== 1'b0 || bus_a.VGA_HS !== 1'b0 ||
        bus_a.VGA_BLANK_n !== 1'b0) begin
      errors++;
      $display("FAIL a_stop_idle: got left=%0d run=%b h=%0d v=%0d pix=%b hs=%b bl=%b, want 0 0 0 0 0 0 0",
               q.size(), bus_a.running, bus_a.hcount, bus_a.vcount, bus_a.pix_en,
               bus_a.VGA_HS, bus_a.VGA_BLANK_n);
    end
    repeat (8) @(negedge clk50);
    checks++;
    if (bus_a.running !== 1'b0 || bus_a.hcount !== 4'd0 || bus_a.VGA_CLK !== 1'b0) begin
      errors++;
      $display("FAIL a_stay_idle: got run=%b h=%0d clk=%b, want 0 0 0",
               bus_a.running, bus_a.hcount, bus_a.VGA_CLK);
    end
  endtask

  // Stop/resume mid-frame, then enable falls on the final pix_en of frame 0.
  task automatic test_frame_stop();
    pix_t q[$];
    pix_t e;
    for (int g = 0; g < 196; g++) q.push_back(model_a(g));
    bus_a.enable = 1'b1;
    for (int t = 0; t < 784; t++) begin
      @(negedge clk50);
      checks++;
      if (bus_a.running !== 1'b1 || bus_a.pix_en !== (t % 4 == 3) ||
          bus_a.frame_start !== (t % 392 == 0)) begin
        errors++;
        $display("FAIL stop_strobe t=%0d: got run/pix/fs=%b%b%b, want 1%b%b", t,
                 bus_a.running, bus_a.pix_en, bus_a.frame_start, t % 4 == 3, t % 392 == 0);
      end
      if (bus_a.pix_en === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stop_pixel t=%0d: got pix_en, want no pixel left", t);
        end else begin
          e = q.pop_front();
          if (bus_a.hcount !== 4'(e.h) || bus_a.vcount !== 3'(e.v) ||
              bus_a.VGA_HS !== e.hs || bus_a.VGA_BLANK_n !== e.bl) begin
            errors++;
            $display("FAIL stop_pixel t=%0d: got h=%0d v=%0d hs=%b bl=%b, want %0d %0d %b %b",
                     t, bus_a.hcount, bus_a.vcount, bus_a.VGA_HS, bus_a.VGA_BLANK_n,
                     e.h, e.v, e.hs, e.bl);
          end
        end
      end
      if (t == 40 || t == 391) bus_a.enable = 1'b0;
      if (t == 60) bus_a.enable = 1'b1;
    end
    @(negedge clk50);
    checks++;
    if (q.size() != 0 || bus_a.running !== 1'b0 || bus_a.hcount !== 4'd0 ||
        bus_a.vcount !== 3'd0 || bus_a.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: got left=%0d run=%b h=%0d v=%0d fs=%b, want 0 0 0 0 0",
               q.size(), bus_a.running, bus_a.hcount, bus_a.vcount, bus_a.frame_start);
    end
  endtask

  task automatic test_pipe_delay();
    pix_t q[$];
    pix_t e;
    int   t_h10 = -1;
    int   t_hs_fall = -1;
    int   t_bl_rise = -1;
    logic hs_prev = 1'b1;
    for (int g = 0; g < 240; g++) q.push_back(model_b(g));
    bus_b.enable = 1'b1;
    for (int t = 0; t < 480; t++) begin
      @(negedge clk50);
      checks++;
      if (bus_b.pix_en !== (t % 2 == 1) || bus_b.frame_start !== (t % 240 == 0)) begin
        errors++;
        $display("FAIL b_strobe t=%0d: got pix/fs=%b%b, want %b%b", t, bus_b.pix_en,
                 bus_b.frame_start, t % 2 == 1, t % 240 == 0);
      end
      if (t_h10 < 0 && bus_b.hcount === 4'd10) t_h10 = t;
      if (t_hs_fall < 0 && hs_prev === 1'b1 && bus_b.VGA_HS === 1'b0) t_hs_fall = t;
      if (t_bl_rise < 0 && bus_b.VGA_BLANK_n === 1'b1) t_bl_rise = t;
      hs_prev = bus_b.VGA_HS;
      if (bus_b.pix_en === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b_pixel t=%0d: got pix_en, want no pixel left", t);
        end else begin
          e = q.pop_front();
          if (bus_b.hcount !== 4'(e.h) || bus_b.vcount !== 3'(e.v) || bus_b.VGA_HS !== e.hs ||
              bus_b.VGA_VS !== e.vs || bus_b.VGA_BLANK_n !== e.bl || bus_b.active !== e.act) begin
            errors++;
            $display("FAIL b_pixel t=%0d: got h=%0d v=%0d hs=%b vs=%b bl=%b act=%b, want %0d %0d %b %b %b %b",
                     t, bus_b.hcount, bus_b.vcount, bus_b.VGA_HS, bus_b.VGA_VS,
                     bus_b.VGA_BLANK_n, bus_b.active, e.h, e.v, e.hs, e.vs, e.bl, e.act);
          end
        end
      end
    end
    bus_b.enable = 1'b0;
    checks++;
    if (t_h10 < 0 || t_hs_fall - t_h10 != 4) begin
      errors++;
      $display("FAIL b_hs_lag: got h10 at %0d, HS fall at %0d, want lag 4", t_h10, t_hs_fall);
    end
    checks++;
    if (t_bl_rise != 4) begin
      errors++;
      $display("FAIL b_blank_lag: got BLANK_n rise at %0d, want 4", t_bl_rise);
    end
  endtask

  task automatic test_defaults();
    pix_t q[$];
    pix_t e;
    int   hs_low = 0;
    for (int g = 0; g < 1600; g++) q.push_back(model_c(g));
    bus_c.enable = 1'b1;
    for (int t = 0; t < 3200; t++) begin
      @(negedge clk50);
      checks++;
      if (bus_c.pix_en !== (t % 2 == 1) || bus_c.VGA_CLK !== (t % 2 == 1) ||
          bus_c.line_start !== (t % 1600 == 0)) begin
        errors++;
        $display("FAIL c_strobe t=%0d: got pix/clk/ls=%b%b%b, want %b%b%b", t, bus_c.pix_en,
                 bus_c.VGA_CLK, bus_c.line_start, t % 2 == 1, t % 2 == 1, t % 1600 == 0);
      end
      if (t < 1600 && bus_c.VGA_HS === 1'b0) hs_low++;
      if (bus_c.pix_en === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL c_pixel t=%0d: got pix_en, want no pixel left", t);
        end else begin
          e = q.pop_front();
          if (bus_c.hcount !== 10'(e.h) || bus_c.vcount !== 10'(e.v) ||
              bus_c.VGA_HS !== e.hs || bus_c.VGA_VS !== e.vs || bus_c.VGA_BLANK_n !== e.bl) begin
            errors++;
            $display("FAIL c_pixel t=%0d: got h=%0d v=%0d hs=%b vs=%b bl=%b, want %0d %0d %b %b %b",
                     t, bus_c.hcount, bus_c.vcount, bus_c.VGA_HS, bus_c.VGA_VS,
                     bus_c.VGA_BLANK_n, e.h, e.v, e.hs, e.vs, e.bl);
          end
        end
      end
    end
    bus_c.enable = 1'b0;
    checks++;
    if (hs_low != 192) begin
      errors++;
      $display("FAIL c_hs_width: got %0d HS-low clocks on line 0, want 192", hs_low);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] got;
    bus_a.enable = 1'b1;
    repeat (190) @(negedge clk50);
    checks++;
    if (bus_a.running !== 1'b1 || bus_a.hcount !== 4'd5 || bus_a.vcount !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre: got run=%b h=%0d v=%0d, want 1 5 3",
               bus_a.running, bus_a.hcount, bus_a.vcount);
    end
    rst_a = 1'b0;
    #1;
    got = {bus_a.running, bus_a.pix_en, bus_a.active, bus_a.line_start, bus_a.frame_start,
           bus_a.VGA_CLK, bus_a.VGA_HS, bus_a.VGA_VS, bus_a.VGA_BLANK_n, bus_a.VGA_SYNC_n};
    checks++;
    if (got !== 10'b0000000001 || bus_a.hcount !== 4'd0 || bus_a.vcount !== 3'd0) begin
      errors++;
      $display("FAIL rst_async: got outs=%b h=%0d v=%0d, want 0000000001 0 0",
               got, bus_a.hcount, bus_a.vcount);
    end
    repeat (4) @(negedge clk50);
    checks++;
    if (bus_a.running !== 1'b0 || bus_a.hcount !== 4'd0 || bus_a.pix_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: got run=%b h=%0d pix=%b, want 0 0 0",
               bus_a.running, bus_a.hcount, bus_a.pix_en);
    end
    rst_a = 1'b1;
    @(negedge clk50);
    checks++;
    if (bus_a.running !== 1'b1 || bus_a.frame_start !== 1'b1 || bus_a.line_start !== 1'b1 ||
        bus_a.hcount !== 4'd0 || bus_a.vcount !== 3'd0) begin
      errors++;
      $display("FAIL rst_restart: got run=%b fs=%b ls=%b h=%0d v=%0d, want 1 1 1 0 0",
               bus_a.running, bus_a.frame_start, bus_a.line_start, bus_a.hcount, bus_a.vcount);
    end
    @(negedge clk50);
    checks++;
    if (bus_a.frame_start !== 1'b0 || bus_a.running !== 1'b1) begin
      errors++;
      $display("FAIL rst_fs_pulse: got fs=%b run=%b, want 0 1", bus_a.frame_start, bus_a.running);
    end
  endtask

  initial begin
    bus_a.enable = 1'b0;
    bus_b.enable = 1'b0;
    bus_c.enable = 1'b0;
    test_reset();
    test_small_frame();
    test_frame_stop();
    test_pipe_delay();
    test_defaults();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
